// File: rtl/block_spawner.sv
// block_spawner
// Streams beatmap entries out of a BRAM (two-cycle read latency) and keeps a
// fixed pool of active block slots for the block_positions stage. An entry is
// placed in a slot once its hit time is within LOOKAHEAD of the game time.
// A slot is freed LINGER time units after its hit time, or as soon as a saber
// strikes it.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   start_in              one-cycle pulse, starts playback at address 0 (IDLE only)
//   curr_time_in          game time, monotonic non-decreasing
//   hit_valid_in/hit_slot_in  saber hit on a slot
//   map_addr_out          BRAM read address
//   map_data_in           BRAM data {x[45:34], y[33:22], time[21:4], color[3], dir[2:0]}
//   block_*_out           per-slot block attributes and occupancy
//   dropped_count_out     stale entries skipped (saturating)
//   map_done_out          end-of-map sentinel reached and every slot is empty
module block_spawner #(
  parameter int NUM_SLOTS  = 12,
  parameter int ADDR_WIDTH = 10,
  parameter int LOOKAHEAD  = 100,
  parameter int LINGER     = 20
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  input  logic [17:0]                 curr_time_in,
  input  logic                        hit_valid_in,
  input  logic [3:0]                  hit_slot_in,
  output logic [ADDR_WIDTH-1:0]       map_addr_out,
  input  logic [45:0]                 map_data_in,
  output logic [NUM_SLOTS-1:0][11:0]  block_x_out,
  output logic [NUM_SLOTS-1:0][11:0]  block_y_out,
  output logic [NUM_SLOTS-1:0][17:0]  block_time_out,
  output logic [NUM_SLOTS-1:0]        block_color_out,
  output logic [NUM_SLOTS-1:0][2:0]   block_direction_out,
  output logic [NUM_SLOTS-1:0]        block_visible_out,
  output logic [7:0]                  dropped_count_out,
  output logic                        map_done_out
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT1 = 3'd2;
  localparam logic [2:0] WAIT2 = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] END   = 3'd5;

  localparam logic [17:0] SENTINEL_TIME = 18'h3FFFF;

  logic [2:0]  state;
  logic [45:0] pending;

  // All time comparisons are done one bit wider so the +LINGER / +LOOKAHEAD
  // sums cannot wrap near the top of the 18-bit time range.
  logic [18:0] curr_ext;
  logic [18:0] data_expire_time;
  logic        data_stale;
  logic        data_sentinel;
  logic        spawn_due;

  assign curr_ext         = {1'b0, curr_time_in};
  assign data_expire_time = {1'b0, map_data_in[21:4]} + 19'(LINGER);
  assign data_stale       = curr_ext > data_expire_time;
  assign data_sentinel    = (map_data_in[21:4] == SENTINEL_TIME);
  assign spawn_due        = (curr_ext + 19'(LOOKAHEAD)) >= {1'b0, pending[21:4]};

  // Lowest-index free slot, taken from the registered visible vector so a
  // slot retired this cycle is only reused on the following cycle.
  logic              free_found;
  logic [SLOT_W-1:0] free_idx;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!block_visible_out[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  logic do_insert;
  assign do_insert = (state == HOLD) && spawn_due && free_found;

  // Retire and insert merged into the next visible vector. The insert target
  // is already invisible, so setting it cannot collide with a retire.
  logic [NUM_SLOTS-1:0] visible_next;

  always_comb begin
    visible_next = block_visible_out;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (curr_ext > ({1'b0, block_time_out[i]} + 19'(LINGER))) begin
        visible_next[i] = 1'b0;
      end
      if (hit_valid_in && (int'(hit_slot_in) == i)) begin
        visible_next[i] = 1'b0;
      end
    end
    if (do_insert) begin
      visible_next[free_idx] = 1'b1;
    end
  end

  assign map_done_out = (state == END) && (block_visible_out == '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= IDLE;
      pending             <= '0;
      map_addr_out        <= '0;
      block_x_out         <= '0;
      block_y_out         <= '0;
      block_time_out      <= '0;
      block_color_out     <= '0;
      block_direction_out <= '0;
      block_visible_out   <= '0;
      dropped_count_out   <= '0;
    end else begin
      block_visible_out <= visible_next;

      if (do_insert) begin
        block_x_out[free_idx]         <= pending[45:34];
        block_y_out[free_idx]         <= pending[33:22];
        block_time_out[free_idx]      <= pending[21:4];
        block_color_out[free_idx]     <= pending[3];
        block_direction_out[free_idx] <= pending[2:0];
      end

      case (state)
        IDLE: begin
          if (start_in) begin
            map_addr_out <= '0;
            state        <= FETCH;
          end
        end
        FETCH: state <= WAIT1;
        WAIT1: state <= WAIT2;
        WAIT2: begin
          pending <= map_data_in;
          if (data_sentinel) begin
            state <= END;
          end else if (data_stale) begin
            if (dropped_count_out != 8'hFF) begin
              dropped_count_out <= dropped_count_out + 8'd1;
            end
            map_addr_out <= map_addr_out + 1'b1;
            state        <= FETCH;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (do_insert) begin
            map_addr_out <= map_addr_out + 1'b1;
            state        <= FETCH;
          end
        end
        END:     state <= END;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_spawner.sv
// tb_block_spawner
// Directed bench for block_spawner. Expected slot load/retire events are
// queued when stimulus is issued; a negedge monitor pops and compares them
// whenever a visible bit changes. Other results are checked directly.
module tb_block_spawner;

  localparam int NS = 12;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 start_in;
  logic [17:0]          curr_time_in;
  logic                 hit_valid_in;
  logic [3:0]           hit_slot_in;
  logic [9:0]           map_addr_out;
  logic [45:0]          map_data_in;
  logic [NS-1:0][11:0]  block_x_out;
  logic [NS-1:0][11:0]  block_y_out;
  logic [NS-1:0][17:0]  block_time_out;
  logic [NS-1:0]        block_color_out;
  logic [NS-1:0][2:0]   block_direction_out;
  logic [NS-1:0]        block_visible_out;
  logic [7:0]           dropped_count_out;
  logic                 map_done_out;

  always #5 clk_in = ~clk_in;

  block_spawner dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .start_in            (start_in),
    .curr_time_in        (curr_time_in),
    .hit_valid_in        (hit_valid_in),
    .hit_slot_in         (hit_slot_in),
    .map_addr_out        (map_addr_out),
    .map_data_in         (map_data_in),
    .block_x_out         (block_x_out),
    .block_y_out         (block_y_out),
    .block_time_out      (block_time_out),
    .block_color_out     (block_color_out),
    .block_direction_out (block_direction_out),
    .block_visible_out   (block_visible_out),
    .dropped_count_out   (dropped_count_out),
    .map_done_out        (map_done_out)
  );

  // Beatmap BRAM model with two cycles of read latency
  logic [45:0] mem [0:1023];
  logic [45:0] rd1 = '0;
  logic [45:0] rd2 = '0;
  always @(posedge clk_in) begin
    rd1 <= mem[map_addr_out];
    rd2 <= rd1;
  end
  assign map_data_in = rd2;

  localparam logic [45:0] SENT = {12'd0, 12'd0, 18'h3FFFF, 1'b0, 3'd0};

  function automatic logic [45:0] ent(input int x, input int y, input int t,
                                      input int c, input int d);
    return {12'(x), 12'(y), 18'(t), 1'(c), 3'(d)};
  endfunction

  int asserts = 0;
  int fails   = 0;

  typedef struct {
    bit          load;
    int          slot;
    logic [45:0] data;
    int          at_time;
  } ev_t;

  ev_t          evq[$];
  logic [NS-1:0] prev_vis = '0;
  bit           mon_skip = 1'b1;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushEv(input bit load, input int slot, input logic [45:0] data,
                        input int at_time);
    ev_t e;
    e.load    = load;
    e.slot    = slot;
    e.data    = data;
    e.at_time = at_time;
    evq.push_back(e);
  endtask

  // Monitor: every visible-bit change must match the next queued event
  always @(negedge clk_in) begin
    if (!mon_skip) begin
      for (int i = 0; i < NS; i++) begin
        if (block_visible_out[i] != prev_vis[i]) begin
          if (evq.size() == 0) begin
            asserts++;
            fails++;
            $display("[TB] FAIL unexpected slot event: slot %0d visible %0b, no event queued",
                     i, block_visible_out[i]);
          end else begin
            ev_t e;
            e = evq.pop_front();
            checkOutput("event kind", 64'(block_visible_out[i]), 64'(e.load));
            checkOutput("event slot", 64'(i), 64'(e.slot));
            if (e.load) begin
              checkOutput("slot fields", {block_x_out[i], block_y_out[i], block_time_out[i],
                                          block_color_out[i], block_direction_out[i]}, e.data);
            end
            if (e.at_time >= 0) begin
              checkOutput("event time", 64'(curr_time_in), 64'(e.at_time));
            end
          end
        end
      end
    end
    prev_vis = block_visible_out;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic hit, input logic [3:0] slot);
    start_in     = start;
    hit_valid_in = hit;
    hit_slot_in  = slot;
    tick(1);
    start_in     = 1'b0;
    hit_valid_in = 1'b0;
    hit_slot_in  = 4'd0;
  endtask

  // Reset for one edge, then confirm every output is cleared
  task automatic resetDut();
    mon_skip = 1'b1;
    rst_in   = 1'b1;
    tick(1);
    rst_in = 1'b0;
    checkOutput("reset visible", 64'(block_visible_out), 64'd0);
    checkOutput("reset addr", 64'(map_addr_out), 64'd0);
    checkOutput("reset dropped", 64'(dropped_count_out), 64'd0);
    checkOutput("reset done", 64'(map_done_out), 64'd0);
    checkOutput("reset x/y zero", 64'((block_x_out == '0) && (block_y_out == '0)), 64'd1);
    checkOutput("reset time/color/dir zero", 64'((block_time_out == '0) &&
                (block_color_out == '0) && (block_direction_out == '0)), 64'd1);
    tick(1);
    mon_skip = 1'b0;
  endtask

  task automatic clearMap();
    for (int i = 0; i < 1024; i++) mem[i] = SENT;
  endtask

  initial begin
    rst_in       = 1'b1;
    start_in     = 1'b0;
    curr_time_in = '0;
    hit_valid_in = 1'b0;
    hit_slot_in  = '0;
    clearMap();

    // Single block: spawn at t=50, linger-retire at t=175, then map done
    $display("[TB] scenario: single block lifetime");
    mem[0] = ent(200, 200, 150, 1, 2);
    mem[1] = SENT;
    resetDut();
    pushEv(1, 0, ent(200, 200, 150, 1, 2), 50);
    pushEv(0, 0, '0, 175);
    applyStimulus(1'b1, 1'b0, 4'd0);
    for (int t = 0; t <= 200; t += 5) begin
      curr_time_in = 18'(t);
      tick(10);
      if (t == 100) checkOutput("done while block visible", 64'(map_done_out), 64'd0);
    end
    checkOutput("single map done", 64'(map_done_out), 64'd1);
    checkOutput("single addr", 64'(map_addr_out), 64'd1);
    checkOutput("single dropped", 64'(dropped_count_out), 64'd0);
    checkOutput("single events drained", 64'(evq.size()), 64'd0);

    // Saber hit retires early; out-of-range hit is ignored
    $display("[TB] scenario: saber hit");
    clearMap();
    mem[0] = ent(200, 200, 150, 1, 2);
    resetDut();
    pushEv(1, 0, ent(200, 200, 150, 1, 2), 50);
    pushEv(0, 0, '0, 100);
    applyStimulus(1'b1, 1'b0, 4'd0);
    for (int t = 0; t <= 95; t += 5) begin
      curr_time_in = 18'(t);
      tick(10);
    end
    applyStimulus(1'b0, 1'b1, 4'd13);
    checkOutput("hit slot 13 ignored", 64'(block_visible_out), 64'h1);
    curr_time_in = 18'd100;
    applyStimulus(1'b0, 1'b1, 4'd0);
    checkOutput("hit clears slot 0", 64'(block_visible_out), 64'h0);
    tick(2);
    checkOutput("hit map done", 64'(map_done_out), 64'd1);
    checkOutput("hit events drained", 64'(evq.size()), 64'd0);

    // Fill all slots, stall in HOLD, then a hit frees slot 5 for entry 12
    $display("[TB] scenario: full slots and stall");
    clearMap();
    for (int i = 0; i < 13; i++) mem[i] = ent(i, i + 100, 200, i % 2, i % 8);
    resetDut();
    curr_time_in = 18'd150;
    for (int i = 0; i < 12; i++) pushEv(1, i, ent(i, i + 100, 200, i % 2, i % 8), -1);
    applyStimulus(1'b1, 1'b0, 4'd0);
    tick(60);
    checkOutput("full visible", 64'(block_visible_out), 64'hFFF);
    checkOutput("stall addr", 64'(map_addr_out), 64'd12);
    checkOutput("fill events drained", 64'(evq.size()), 64'd0);
    pushEv(0, 5, '0, -1);
    pushEv(1, 5, ent(12, 112, 200, 0, 4), -1);
    applyStimulus(1'b0, 1'b1, 4'd5);
    checkOutput("slot 5 free in hit cycle", 64'(block_visible_out), 64'hFDF);
    checkOutput("addr held in hit cycle", 64'(map_addr_out), 64'd12);
    tick(1);
    checkOutput("slot 5 reloaded", 64'(block_visible_out), 64'hFFF);
    checkOutput("slot 5 x", 64'(block_x_out[5]), 64'd12);
    checkOutput("slot 4 x untouched", 64'(block_x_out[4]), 64'd4);
    tick(6);
    checkOutput("post-stall addr", 64'(map_addr_out), 64'd13);
    checkOutput("not done with full slots", 64'(map_done_out), 64'd0);
    checkOutput("stall events drained", 64'(evq.size()), 64'd0);

    // Stale entries are dropped; the live one spawns at t=400
    $display("[TB] scenario: stale entries");
    clearMap();
    mem[0] = ent(1, 1, 10, 0, 1);
    mem[1] = ent(2, 2, 20, 1, 3);
    mem[2] = ent(3, 4, 500, 1, 5);
    resetDut();
    curr_time_in = 18'd100;
    applyStimulus(1'b1, 1'b0, 4'd0);
    tick(30);
    checkOutput("dropped count", 64'(dropped_count_out), 64'd2);
    checkOutput("stale nothing visible", 64'(block_visible_out), 64'h0);
    checkOutput("stale addr", 64'(map_addr_out), 64'd2);
    curr_time_in = 18'd395;
    tick(10);
    checkOutput("no early spawn", 64'(block_visible_out), 64'h0);
    pushEv(1, 0, ent(3, 4, 500, 1, 5), 400);
    curr_time_in = 18'd400;
    tick(5);
    checkOutput("late entry visible", 64'(block_visible_out), 64'h1);
    checkOutput("stale events drained", 64'(evq.size()), 64'd0);

    // start ignored in HOLD; reset mid-HOLD; restart re-reads from 0
    $display("[TB] scenario: start in HOLD and reset mid-playback");
    clearMap();
    for (int i = 0; i < 3; i++) mem[i] = ent(10 + i, 20 + i, 200, 0, i);
    mem[3] = ent(99, 99, 1000, 1, 7);
    resetDut();
    curr_time_in = 18'd150;
    for (int i = 0; i < 3; i++) pushEv(1, i, ent(10 + i, 20 + i, 200, 0, i), -1);
    applyStimulus(1'b1, 1'b0, 4'd0);
    tick(30);
    checkOutput("three visible", 64'(block_visible_out), 64'h7);
    checkOutput("hold addr", 64'(map_addr_out), 64'd3);
    applyStimulus(1'b1, 1'b0, 4'd0);
    tick(5);
    checkOutput("start in HOLD addr", 64'(map_addr_out), 64'd3);
    checkOutput("start in HOLD visible", 64'(block_visible_out), 64'h7);
    checkOutput("start in HOLD slot0 x", 64'(block_x_out[0]), 64'd10);
    checkOutput("start in HOLD slot2 time", 64'(block_time_out[2]), 64'd200);
    checkOutput("hold events drained", 64'(evq.size()), 64'd0);
    resetDut();
    for (int i = 0; i < 3; i++) pushEv(1, i, ent(10 + i, 20 + i, 200, 0, i), -1);
    applyStimulus(1'b1, 1'b0, 4'd0);
    tick(30);
    checkOutput("restart visible", 64'(block_visible_out), 64'h7);
    checkOutput("restart addr", 64'(map_addr_out), 64'd3);
    checkOutput("restart events drained", 64'(evq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/block_spawner.md
Name: block_spawner

Overview:
- Producer for the block-position pipeline: streams the beatmap from a BRAM and maintains 12 active block slots.
- Drives the block_x/y/time/color/direction/visible arrays consumed by block_positions.
- Loads each block LOOKAHEAD time units before its hit time.
- Retires a block LINGER units after its hit time, or immediately on a saber hit.

Parameters:
- NUM_SLOTS, 12, active block slots (array depth of all block_* outputs).
- ADDR_WIDTH, 10, beatmap BRAM address width.
- LOOKAHEAD, 100, spawn when block_time - curr_time <= LOOKAHEAD.
- LINGER, 20, retire when curr_time > block_time + LINGER.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  one-cycle pulse; begins map playback from address 0.
- curr_time_in  input  18  game time, monotonic non-decreasing.
- hit_valid_in  input  1  one-cycle pulse: block in hit_slot_in was struck.
- hit_slot_in  input  4  slot index of the struck block.
- map_addr_out  output  ADDR_WIDTH  BRAM read address.
- map_data_in  input  46  BRAM data, valid 2 cycles after the address is presented. Layout: [45:34] x, [33:22] y, [21:4] time, [3] color, [2:0] direction. time=18'h3FFFF is the end-of-map sentinel.
- block_x_out  output  NUM_SLOTS x 12  per-slot x.
- block_y_out  output  NUM_SLOTS x 12  per-slot y.
- block_time_out  output  NUM_SLOTS x 18  per-slot hit time.
- block_color_out  output  NUM_SLOTS  per-slot color.
- block_direction_out  output  NUM_SLOTS x 3  per-slot direction.
- block_visible_out  output  NUM_SLOTS  slot occupied.
- dropped_count_out  output  8  entries skipped because they were already stale; saturates at 255.
- map_done_out  output  1  sentinel reached and all slots empty.

Behaviour:
- Reset: all outputs 0 (all block_* arrays, visible, map_addr_out, dropped_count_out, map_done_out); FSM to IDLE. Reset mid-playback aborts immediately; no partial state survives.
- FSM states: IDLE, FETCH, WAIT1, WAIT2, HOLD, END.
  - IDLE: on start_in, map_addr_out<=0, go to FETCH. start_in in any other state is ignored.
  - FETCH: address is stable; go to WAIT1, then WAIT2.
  - WAIT2: register map_data_in into the pending entry.
    - Sentinel: go to END.
    - Stale entry (curr_time > time + LINGER): increment dropped_count, increment the address, go to FETCH.
    - Otherwise: go to HOLD.
  - HOLD: wait until curr_time + LOOKAHEAD >= pending time AND at least one slot has visible=0.
    - Then write the pending entry into the lowest-index free slot and set its visible bit.
    - Increment the address and go to FETCH.
    - Minimum 4 cycles per entry.
  - END: map_done_out=1 whenever block_visible_out==0; stays in END until reset. map_done_out can drop back to 0 only by reset.
- Comparisons: use 19-bit unsigned arithmetic so time+LINGER and curr_time+LOOKAHEAD never wrap.
- Retire (every cycle, all slots in parallel, any state):
  - Clear visible for slots with curr_time > time + LINGER.
  - Clear visible for slot hit_slot_in when hit_valid_in is asserted.
  - Ignore hits on invisible slots and on hit_slot_in >= NUM_SLOTS.
  - Retire clears only the visible bit; x/y/time/color/direction hold their last values.
- Same-cycle insert and retire: free-slot selection uses the registered visible vector (pre-retire). A slot freed this cycle is not reused until the next cycle, so there is never a write conflict.
- Address increment wraps at 2^ADDR_WIDTH. The beatmap must contain a sentinel before the wrap.
- All slots full in HOLD: stall, with the address held, until a slot frees.

Test Plan:
- Entry 0 = {x=200,y=200,t=150,color=1,dir=2}, entry 1 = sentinel; start_in at curr_time=0, curr_time +=5 every 10 cycles -> slot 0 loads the cycle after curr_time reaches 50; visible[0] clears once curr_time=175; then map_done_out=1.
- Hit: same map, hit_valid_in with hit_slot_in=0 at curr_time=100 -> visible[0]=0 the next cycle, map_done_out=1. hit_slot_in=13 -> no change.
- 13 entries all t=200, curr_time held at 150 -> slots 0-11 filled in order; FSM stalls in HOLD with map_addr_out=12. Hit on slot 5 -> entry 12 lands in slot 5 one cycle later (not in the hit cycle).
- Stale entries: entries t=10, t=20, t=500, start_in at curr_time=100 -> dropped_count_out=2; t=500 entry loads at curr_time=400.
- Reset mid-HOLD with 3 slots visible -> next cycle all outputs 0 and FSM in IDLE. A new start_in re-reads from address 0.
- start_in pulsed during HOLD -> ignored; address and slot contents unchanged.
